mac_pipe: RTL

- Parametrised, pipelined multiply-accumulate engine. Successor to the single T/P/accumulator datapath in the dsp core.
- Keeps the T (multiplicand) register and the P (product) register.
- Generalises the accumulator to NUM_ACC independent channels, each with optional saturating overflow mode.
- Adds a 3-stage pipeline with valid/ready handshakes on both the command side and the readback side.
- The core's decoder drives commands into it. Readback results return to the data bus mux.

---
 rtl/mac_pipe.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/mac_pipe.sv
// mac_pipe: three-stage pipelined multiply-accumulate engine.
// S1 holds the accepted command. S2 updates T/P. S3 updates one of NUM_ACC
// accumulators, or captures a readback. When a result is waiting on the output
// and the consumer is not ready, the whole pipeline stalls.
module mac_pipe #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned NUM_ACC   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 op,
  input  logic [$clog2(NUM_ACC)-1:0] acc_sel,
  input  logic [WIDTH-1:0]           operand,
  input  logic                       sat_en,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_WIDTH-1:0]       out_acc,
  output logic [$clog2(NUM_ACC)-1:0] out_sel,
  output logic                       ovf,
  output logic                       busy
);

  localparam int unsigned SelW = $clog2(NUM_ACC);

  localparam logic [ACC_WIDTH-1:0] AccMax = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] AccMin = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    OpNop  = 3'd0,
    OpLt   = 3'd1,
    OpMpy  = 3'd2,
    OpLta  = 3'd3,
    OpApac = 3'd4,
    OpSpac = 3'd5,
    OpZac  = 3'd6,
    OpRd   = 3'd7
  } op_e;

  // Pipeline stage registers
  logic                    s1_valid_q, s2_valid_q, s3_valid_q;
  op_e                     s1_op_q, s2_op_q, s3_op_q;
  logic [SelW-1:0]         s1_sel_q, s2_sel_q, s3_sel_q;
  logic signed [WIDTH-1:0] s1_operand_q, s2_operand_q;
  logic                    s1_sat_q, s2_sat_q, s3_sat_q;

  // Architectural state
  logic signed [WIDTH-1:0]     t_q;
  logic signed [2*WIDTH-1:0]   p_q;
  logic signed [ACC_WIDTH-1:0] acc_q [NUM_ACC];

  logic                 out_valid_q;
  logic [ACC_WIDTH-1:0] out_acc_q;
  logic [SelW-1:0]      out_sel_q;
  logic                 ovf_q;

  logic advance;
  logic in_sel_ok;

  logic signed [2*WIDTH-1:0]   prod;
  logic signed [ACC_WIDTH-1:0] acc_cur;
  logic signed [ACC_WIDTH-1:0] p_ext;
  logic signed [ACC_WIDTH:0]   sum;
  logic                        sum_ovf;
  logic [ACC_WIDTH-1:0]        acc_new;
  logic                        acc_we;
  logic                        ovf_set;
  logic                        rd_done;

  // The pipeline only moves when no result is stuck waiting on the consumer.
  assign advance  = !(out_valid_q && !out_ready);
  assign in_ready = advance;
  assign busy     = s1_valid_q | s2_valid_q | s3_valid_q;

  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign out_sel   = out_sel_q;
  assign ovf       = ovf_q;

  // A channel index past NUM_ACC only exists when NUM_ACC is not a power of two.
  if ((1 << SelW) != NUM_ACC) begin : g_sel_chk
    assign in_sel_ok = ({1'b0, acc_sel} < (SelW + 1)'(NUM_ACC));
  end else begin : g_sel_all
    assign in_sel_ok = 1'b1;
  end

  assign prod = (2 * WIDTH)'(t_q) * (2 * WIDTH)'(s2_operand_q);

  // Advance the command through S1 -> S2 -> S3. Invalid slots carry NOP.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      s3_valid_q   <= 1'b0;
      s1_op_q      <= OpNop;
      s2_op_q      <= OpNop;
      s3_op_q      <= OpNop;
      s1_sel_q     <= '0;
      s2_sel_q     <= '0;
      s3_sel_q     <= '0;
      s1_operand_q <= '0;
      s2_operand_q <= '0;
      s1_sat_q     <= 1'b0;
      s2_sat_q     <= 1'b0;
      s3_sat_q     <= 1'b0;
    end else if (advance) begin
      s1_valid_q   <= in_valid;
      s1_op_q      <= (in_valid && in_sel_ok) ? op_e'(op) : OpNop;
      s1_sel_q     <= acc_sel;
      s1_operand_q <= operand;
      s1_sat_q     <= sat_en;
      s2_valid_q   <= s1_valid_q;
      s2_op_q      <= s1_op_q;
      s2_sel_q     <= s1_sel_q;
      s2_operand_q <= s1_operand_q;
      s2_sat_q     <= s1_sat_q;
      s3_valid_q   <= s2_valid_q;
      s3_op_q      <= s2_op_q;
      s3_sel_q     <= s2_sel_q;
      s3_sat_q     <= s2_sat_q;
    end
  end

  // S2: update T and P. A following command in S2 sees the new T,
  // and a following command in S3 sees the new P.
  always_ff @(posedge clk) begin
    if (reset) begin
      t_q <= '0;
      p_q <= '0;
    end else if (advance && s2_valid_q) begin
      case (s2_op_q)
        OpLt, OpLta: t_q <= s2_operand_q;
        OpMpy:       p_q <= prod;
        default:     ;
      endcase
    end
  end

  // S3: compute the accumulator update in ACC_WIDTH+1 bits.
  // Overflow is detected and the result is optionally clamped.
  always_comb begin
    acc_cur = acc_q[s3_sel_q];
    p_ext   = ACC_WIDTH'(p_q);
    sum     = (s3_op_q == OpSpac) ? ((ACC_WIDTH + 1)'(acc_cur) - (ACC_WIDTH + 1)'(p_ext))
                                  : ((ACC_WIDTH + 1)'(acc_cur) + (ACC_WIDTH + 1)'(p_ext));
    sum_ovf = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
    acc_new = acc_cur;
    acc_we  = 1'b0;
    ovf_set = 1'b0;
    rd_done = 1'b0;
    if (advance && s3_valid_q) begin
      case (s3_op_q)
        OpLta, OpApac, OpSpac: begin
          acc_we  = 1'b1;
          ovf_set = sum_ovf;
          if (sum_ovf && s3_sat_q) begin
            acc_new = sum[ACC_WIDTH] ? AccMin : AccMax;
          end else begin
            acc_new = sum[ACC_WIDTH-1:0];
          end
        end
        OpZac: begin
          acc_we  = 1'b1;
          acc_new = '0;
        end
        OpRd:    rd_done = 1'b1;
        default: ;
      endcase
    end
  end

  // Accumulator bank write
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_ACC); i++) begin
        acc_q[i] <= '0;
      end
    end else if (acc_we) begin
      acc_q[s3_sel_q] <= acc_new;
    end
  end

  // Output register. A completing RD takes priority over clearing on handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_sel_q   <= '0;
    end else if (rd_done) begin
      out_valid_q <= 1'b1;
      out_acc_q   <= acc_cur;
      out_sel_q   <= s3_sel_q;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Sticky overflow flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (ovf_set) begin
      ovf_q <= 1'b1;
    end
  end

endmodule
